e_mdu: RTL

- Multiply/divide unit in the E stage, beside the ALU. Executes mult, multu, div, divu, mthi and mtlo.
- Holds the architectural HI/LO registers and serves mfhi/mflo reads.
- Models multi-cycle latency with a countdown counter. The stall unit uses `start` and `busy` to hold dependent md instructions in D.

---
 rtl/e_mdu.sv | 120 ++++++++++++
 1 files changed

// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
// Module   : e_mdu
// Brief    : E-stage multiply/divide unit holding HI/LO, with a countdown
//            modelling multi-cycle mult/div latency.
// Revision : 1.0
// ============================================================================
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        readHi,
    output logic        busy,
    output logic [31:0] mdResult
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [31:0]      hi, lo;
    logic [31:0]      pend_hi, pend_lo;
    logic [CNT_W-1:0] cnt;
    logic             div_zero;

    logic [63:0] prod_s, prod_u;
    logic        is_signed_div;
    logic [31:0] a_mag, b_mag, dvnd, dvsr;
    logic [31:0] q_u, r_u, quot, rem;

    always_comb begin
        prod_s = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
        prod_u = {32'd0, srcA} * {32'd0, srcB};
    end

    // Signed division runs on magnitudes so the 0x80000000/-1 overflow case and
    // truncation toward zero fall out naturally; a zero divisor is substituted
    // to keep the divider defined, and the commit is suppressed instead.
    always_comb begin
        is_signed_div = (mdOp == OP_DIV);
        a_mag = srcA[31] ? (32'd0 - srcA) : srcA;
        b_mag = srcB[31] ? (32'd0 - srcB) : srcB;
        dvnd  = is_signed_div ? a_mag : srcA;
        dvsr  = is_signed_div ? b_mag : srcB;
        if (dvsr == 32'd0) begin
            dvsr = 32'd1;
        end
        q_u  = dvnd / dvsr;
        r_u  = dvnd % dvsr;
        quot = q_u;
        rem  = r_u;
        if (is_signed_div) begin
            quot = (srcA[31] ^ srcB[31]) ? (32'd0 - q_u) : q_u;
            rem  = srcA[31] ? (32'd0 - r_u) : r_u;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi       <= 32'd0;
            lo       <= 32'd0;
            pend_hi  <= 32'd0;
            pend_lo  <= 32'd0;
            cnt      <= '0;
            busy     <= 1'b0;
            div_zero <= 1'b0;
        end else if (busy) begin
            // Any start arriving while busy is a protocol violation and is dropped.
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
                if (!div_zero) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
        end else if (start) begin
            case (mdOp)
                OP_MULT: begin
                    {pend_hi, pend_lo} <= prod_s;
                    div_zero <= 1'b0;
                    cnt      <= CNT_W'(MULT_CYCLES);
                    busy     <= 1'b1;
                end
                OP_MULTU: begin
                    {pend_hi, pend_lo} <= prod_u;
                    div_zero <= 1'b0;
                    cnt      <= CNT_W'(MULT_CYCLES);
                    busy     <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    pend_hi  <= rem;
                    pend_lo  <= quot;
                    div_zero <= (srcB == 32'd0);
                    cnt      <= CNT_W'(DIV_CYCLES);
                    busy     <= 1'b1;
                end
                OP_MTHI: hi <= srcA;
                OP_MTLO: lo <= srcA;
                default: ;
            endcase
        end
    end

    assign mdResult = readHi ? hi : lo;

endmodule
`default_nettype wire
